frame_capture_ctrl: RTL and testbench
=====================================

Name: frame_capture_ctrl

Overview:
Sequences the 320x240 grayscale frame buffer between live camera writes and frozen-frame processing. Gates the write-side enable so that exactly one whole camera frame is captured on request, then holds the buffer frozen. On request it runs an address sweep over the read port for the downstream processing stage, with a ready handshake and matching data-valid timing. Sits between the rotate/grayscale write path and the frame buffer BRAM; all of its logic runs on the 65 MHz system clock.

Parameters:
FRAME_PIXELS, 76800, pixels per frame (320*240); write-count target and sweep length.
ADDR_WIDTH, 17, width of frame buffer addresses and counters.
READ_LATENCY, 2, BRAM read latency in clk_in cycles; rd_valid_out delay.
TIMEOUT_CYCLES, 2000000, watchdog limit (optional feature only).

Ports:
clk_in  input  1  system clock (65 MHz)
rst_in  input  1  synchronous active-high reset
capture_in  input  1  single-cycle capture request (debounced button)
live_in  input  1  level; return to live mode from FROZEN
sweep_start_in  input  1  single-cycle request to sweep the frozen frame
frame_start_in  input  1  single-cycle pulse at camera frame start, already synchronized to clk_in
pixel_valid_in  input  1  valid rotated pixel for the write port
wea_out  output  1  frame buffer write enable
frozen_out  output  1  high in FROZEN or SWEEP
busy_out  output  1  high in ARM, CAPTURE or SWEEP
capture_done_out  output  1  single-cycle pulse when a capture completes
rd_ready_in  input  1  consumer can accept a read this cycle
rd_en_out  output  1  read issued this cycle
rd_addr_out  output  ADDR_WIDTH  read address
rd_valid_out  output  1  BRAM data valid; asserts READ_LATENCY cycles after rd_en_out
rd_last_out  output  1  accompanies rd_valid_out for address FRAME_PIXELS-1
sweep_done_out  output  1  single-cycle pulse with the final rd_valid_out
retry_count_out  output  8  number of aborted captures, saturating

Behaviour:
- Reset: state LIVE; all outputs 0; counters 0; read pipeline flushed.
- wea_out is combinational: pixel_valid_in in LIVE, ARM and CAPTURE; 0 in FROZEN and SWEEP.
- LIVE: capture_in -> ARM.
- ARM: waits for frame_start_in -> CAPTURE, clearing the write counter. capture_in while in ARM is ignored.
- CAPTURE: each pixel_valid_in increments the write counter.
  - When the counter reaches FRAME_PIXELS: -> FROZEN and pulse capture_done_out on the same edge.
  - frame_start_in before the counter reaches FRAME_PIXELS (short frame): retry_count_out++ (saturates at 255), clear the counter, stay in CAPTURE for the new frame.
  - If frame_start_in and the final pixel arrive in the same cycle, the final pixel wins (completion).
- FROZEN:
  - capture_in -> ARM (recapture).
  - Otherwise sweep_start_in -> SWEEP with the read counter at 0.
  - Otherwise live_in -> LIVE.
  - Priority: capture_in > sweep_start_in > live_in.
- SWEEP:
  - Each cycle with rd_ready_in=1: rd_en_out=1, rd_addr_out=counter, counter++.
  - With rd_ready_in=0: rd_en_out=0 and rd_addr_out holds.
  - After issuing address FRAME_PIXELS-1: -> FROZEN. rd_valid_out and rd_last_out still drain READ_LATENCY cycles later; sweep_done_out pulses with the last rd_valid_out.
  - capture_in, live_in and sweep_start_in are ignored during SWEEP.
- Read pipeline: rd_valid_out and rd_last_out form a READ_LATENCY-deep shift register of rd_en_out and the last flag. It is cleared only by rst_in.
- rst_in mid-operation: returns to LIVE next edge; in-flight reads are dropped (no rd_valid_out).

Optional Feature:
CAPTURE_TIMEOUT_EN
- Defined: a watchdog counts cycles spent in ARM or CAPTURE and clears on any other state. Reaching TIMEOUT_CYCLES -> LIVE with a 1-cycle pulse on an extra output timeout_out (camera stalled or no frame_start_in).
- Undefined: no watchdog; ARM and CAPTURE wait indefinitely; timeout_out is tied 0.

Test Plan:
- Reset then pixel_valid_in toggling -> wea_out follows pixel_valid_in; frozen_out=0, busy_out=0, all rd_* = 0.
- capture_in, frame_start_in 5 cycles later, 76800 valid pixels -> capture_done_out pulses on the 76800th pixel edge; wea_out=0 afterwards despite pixel_valid_in=1; frozen_out=1.
- Short frame: frame_start_in after 1000 pixels in CAPTURE -> retry_count_out=1, still busy; full next frame -> capture_done_out.
- Sweep with rd_ready_in toggling 1,0,1,... -> addresses 0..76799 issued exactly once in order; each rd_valid_out arrives exactly 2 cycles after its rd_en_out; rd_last_out and sweep_done_out together once; final state FROZEN.
- In FROZEN, assert capture_in and sweep_start_in in the same cycle -> ARM entered, no rd_en_out; later live_in alone -> LIVE.
- rst_in during SWEEP at address 300 -> next cycle LIVE, rd_valid_out never asserts afterwards. With CAPTURE_TIMEOUT_EN and TIMEOUT_CYCLES=100: capture_in and no frame_start_in -> timeout_out pulse at cycle 100 and state LIVE.

Source files
------------

// File: rtl/frame_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : frame_capture_ctrl
//  Purpose  : Sequences the 320x240 grayscale frame buffer between live
//             camera writes and a frozen frame. Captures exactly one whole
//             camera frame on request, then sweeps the frozen frame out of
//             the read port with a ready handshake and aligned data-valid.
//  Options  : CAPTURE_TIMEOUT_EN - watchdog on ARM/CAPTURE that returns to
//             LIVE and pulses timeout_out after TIMEOUT_CYCLES cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_capture_ctrl #(
    parameter int FRAME_PIXELS   = 76800,
    parameter int ADDR_WIDTH     = 17,
    parameter int READ_LATENCY   = 2,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  capture_in,
    input  logic                  live_in,
    input  logic                  sweep_start_in,
    input  logic                  frame_start_in,
    input  logic                  pixel_valid_in,
    output logic                  wea_out,
    output logic                  frozen_out,
    output logic                  busy_out,
    output logic                  capture_done_out,
    input  logic                  rd_ready_in,
    output logic                  rd_en_out,
    output logic [ADDR_WIDTH-1:0] rd_addr_out,
    output logic                  rd_valid_out,
    output logic                  rd_last_out,
    output logic                  sweep_done_out,
    output logic [7:0]            retry_count_out,
    output logic                  timeout_out
);

    typedef enum logic [2:0] {
        ST_LIVE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_FROZEN  = 3'd3,
        ST_SWEEP   = 3'd4
    } state_t;

    // Last valid pixel address; also the write count one pixel before completion.
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(FRAME_PIXELS - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_wr_count;
    logic [ADDR_WIDTH-1:0]   r_rd_count;
    logic [7:0]              r_retry;
    logic                    r_cap_done;
    logic [READ_LATENCY-1:0] r_valid_pipe;
    logic [READ_LATENCY-1:0] r_last_pipe;

    logic w_wr_clear;
    logic w_wr_inc;
    logic w_cap_done;
    logic w_short_frame;
    logic w_sweep_start;
    logic w_rd_en;
    logic w_rd_last;
    logic w_in_acquire;

    assign w_in_acquire = (r_state == ST_ARM) || (r_state == ST_CAPTURE);

`ifdef CAPTURE_TIMEOUT_EN
    localparam int c_wdog_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(TIMEOUT_CYCLES - 1);

    logic [c_wdog_w-1:0] r_wdog;
    logic                r_timeout;
    logic                w_timeout;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= ST_LIVE;
        else        r_state <= w_state_next;
    end

    // Next-state decode plus the one-cycle strobes that drive the counters.
    always_comb begin
        w_state_next  = r_state;
        w_wr_clear    = 1'b0;
        w_wr_inc      = 1'b0;
        w_cap_done    = 1'b0;
        w_short_frame = 1'b0;
        w_sweep_start = 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
        w_timeout     = 1'b0;
`endif
        case (r_state)
            ST_LIVE: begin
                if (capture_in) w_state_next = ST_ARM;
            end
            ST_ARM: begin
                if (frame_start_in) begin
                    w_state_next = ST_CAPTURE;
                    w_wr_clear   = 1'b1;
                end
            end
            ST_CAPTURE: begin
                // The final pixel beats a coincident frame start.
                if (pixel_valid_in && (r_wr_count == c_last_addr)) begin
                    w_state_next = ST_FROZEN;
                    w_cap_done   = 1'b1;
                end else if (frame_start_in) begin
                    w_short_frame = 1'b1;
                    w_wr_clear    = 1'b1;
                end else if (pixel_valid_in) begin
                    w_wr_inc = 1'b1;
                end
            end
            ST_FROZEN: begin
                if (capture_in) begin
                    w_state_next = ST_ARM;
                end else if (sweep_start_in) begin
                    w_state_next  = ST_SWEEP;
                    w_sweep_start = 1'b1;
                end else if (live_in) begin
                    w_state_next = ST_LIVE;
                end
            end
            ST_SWEEP: begin
                if (rd_ready_in && (r_rd_count == c_last_addr)) w_state_next = ST_FROZEN;
            end
            default: w_state_next = ST_LIVE;
        endcase
`ifdef CAPTURE_TIMEOUT_EN
        // A completing capture is allowed to finish even on the last watchdog cycle.
        if (w_in_acquire && !w_cap_done && (r_wdog == c_wdog_last)) begin
            w_state_next = ST_LIVE;
            w_timeout    = 1'b1;
        end
`endif
    end

    // Status and read-issue decode; the write enable gates the camera path directly.
    assign wea_out    = pixel_valid_in && (r_state == ST_LIVE || w_in_acquire);
    assign frozen_out = (r_state == ST_FROZEN) || (r_state == ST_SWEEP);
    assign busy_out   = w_in_acquire || (r_state == ST_SWEEP);
    assign w_rd_en    = (r_state == ST_SWEEP) && rd_ready_in;
    assign w_rd_last  = w_rd_en && (r_rd_count == c_last_addr);

    assign rd_en_out        = w_rd_en;
    assign rd_addr_out      = r_rd_count;
    assign capture_done_out = r_cap_done;
    assign retry_count_out  = r_retry;
    assign rd_valid_out     = r_valid_pipe[READ_LATENCY-1];
    assign rd_last_out      = r_last_pipe[READ_LATENCY-1];
    assign sweep_done_out   = rd_valid_out && rd_last_out;

    // Write-side pixel counter for the frame being captured.
    always_ff @(posedge clk_in) begin
        if (rst_in)          r_wr_count <= '0;
        else if (w_wr_clear) r_wr_count <= '0;
        else if (w_wr_inc)   r_wr_count <= r_wr_count + 1'b1;
    end

    // Read address counter; it parks on the last address once the sweep ends.
    always_ff @(posedge clk_in) begin
        if (rst_in)                                      r_rd_count <= '0;
        else if (w_sweep_start)                          r_rd_count <= '0;
        else if (w_rd_en && (r_rd_count != c_last_addr)) r_rd_count <= r_rd_count + 1'b1;
    end

    // Aborted-capture counter (saturating) and the capture-complete pulse.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_retry    <= 8'd0;
            r_cap_done <= 1'b0;
        end else begin
            r_cap_done <= w_cap_done;
            if (w_short_frame && (r_retry != 8'hFF)) r_retry <= r_retry + 8'd1;
        end
    end

    // Read-valid/last delay line matching the BRAM read latency.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid_pipe <= '0;
            r_last_pipe  <= '0;
        end else begin
            r_valid_pipe[0] <= w_rd_en;
            r_last_pipe[0]  <= w_rd_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_valid_pipe[i] <= r_valid_pipe[i-1];
                r_last_pipe[i]  <= r_last_pipe[i-1];
            end
        end
    end

`ifdef CAPTURE_TIMEOUT_EN
    // Watchdog on time spent waiting for or receiving a frame.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
            if (w_in_acquire && !w_timeout) r_wdog <= r_wdog + 1'b1;
            else                            r_wdog <= '0;
        end
    end

    assign timeout_out = r_timeout;
`else
    assign timeout_out = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_capture_ctrl
//  Purpose  : Self-checking bench for frame_capture_ctrl (reduced frame size).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_capture_ctrl;

    localparam int FP = 1500;
    localparam int AW = 17;
    localparam int RL = 2;
    localparam int TO = 100;

    logic          clk_in = 1'b0;
    logic          rst_in, capture_in, live_in, sweep_start_in;
    logic          frame_start_in, pixel_valid_in, rd_ready_in;
    logic          wea_out, frozen_out, busy_out, capture_done_out;
    logic          rd_en_out, rd_valid_out, rd_last_out, sweep_done_out, timeout_out;
    logic [AW-1:0] rd_addr_out;
    logic [7:0]    retry_count_out;

    always #5 clk_in = ~clk_in;

    frame_capture_ctrl #(
        .FRAME_PIXELS(FP), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .capture_in(capture_in), .live_in(live_in),
        .sweep_start_in(sweep_start_in), .frame_start_in(frame_start_in),
        .pixel_valid_in(pixel_valid_in), .wea_out(wea_out), .frozen_out(frozen_out),
        .busy_out(busy_out), .capture_done_out(capture_done_out), .rd_ready_in(rd_ready_in),
        .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out), .rd_valid_out(rd_valid_out),
        .rd_last_out(rd_last_out), .sweep_done_out(sweep_done_out),
        .retry_count_out(retry_count_out), .timeout_out(timeout_out)
    );

    typedef struct {
        logic pix;
        logic rdy;
        logic live;
        logic exp_wea;
    } vec_t;

    typedef struct {
        int   due;
        logic last;
    } sb_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    vec_t vt[6];
    sb_t  sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic capture_pulse();
        capture_in = 1'b1;
        #3;
        check("busy_before_arm", busy_out, 1'b0);
        step();
        capture_in = 1'b0;
    endtask

    // Four ARM cycles with pixels present (must not count), then frame start.
    task automatic arm_and_start();
        for (int i = 0; i < 4; i++) begin
            pixel_valid_in = 1'b1;
            rd_ready_in    = 1'b1;
            #3;
            check("arm_wea", wea_out, 1'b1);
            check("arm_busy", busy_out, 1'b1);
            check("arm_frozen", frozen_out, 1'b0);
            check("arm_rd_en", rd_en_out, 1'b0);
            step();
        end
        pixel_valid_in = 1'b0;
        rd_ready_in    = 1'b0;
        frame_start_in = 1'b1;
        #3;
        step();
        frame_start_in = 1'b0;
    endtask

    task automatic feed_pixels(input int n, input bit fs_on_last);
        int cnt   = 0;
        int guard = 0;
        while (cnt < n && guard < 4 * n + 16) begin
            pixel_valid_in = ($urandom_range(0, 4) != 0);
            frame_start_in = fs_on_last && pixel_valid_in && (cnt == n - 1);
            #3;
            check("cap_wea", wea_out, pixel_valid_in);
            check("cap_done_early", capture_done_out, 1'b0);
            check("cap_busy", busy_out, 1'b1);
            if (pixel_valid_in) cnt++;
            step();
            guard++;
        end
        frame_start_in = 1'b0;
        check("pixel_budget", cnt, n);
    endtask

    task automatic finish_capture(input bit fs_on_last, input logic [7:0] exp_retry);
        feed_pixels(FP, fs_on_last);
        pixel_valid_in = 1'b1;
        #3;
        check("done_pulse", capture_done_out, 1'b1);
        check("done_frozen", frozen_out, 1'b1);
        check("done_busy", busy_out, 1'b0);
        check("frozen_wea", wea_out, 1'b0);
        check("done_retry", retry_count_out, exp_retry);
        step();
        #3;
        check("done_single", capture_done_out, 1'b0);
        check("frozen_wea2", wea_out, 1'b0);
        step();
        pixel_valid_in = 1'b0;
    endtask

    task automatic full_sweep();
        int   exp_addr = 0;
        int   n_last   = 0;
        int   n_done   = 0;
        sb_t  e;
        sweep_start_in = 1'b1;
        rd_ready_in    = 1'b0;
        #3;
        check("sweep_req_rd_en", rd_en_out, 1'b0);
        step();
        sweep_start_in = 1'b0;
        for (int k = 0; k < 4 * FP + 20 && !(exp_addr == FP && sb.size() == 0); k++) begin
            rd_ready_in = (k % 2 == 0);
            capture_in  = (k == 7);
            live_in     = (k == 9);
            #3;
            check("sweep_rd_en", rd_en_out, rd_ready_in && (exp_addr < FP));
            if (rd_en_out) begin
                check("sweep_addr", rd_addr_out, exp_addr);
                sb.push_back('{due: cyc + RL, last: (exp_addr == FP - 1)});
                exp_addr++;
            end
            if (rd_valid_out) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("valid_latency", cyc, e.due);
                    check("valid_last", rd_last_out, e.last);
                    check("valid_done", sweep_done_out, e.last);
                end
            end else begin
                check("idle_done", sweep_done_out, 1'b0);
            end
            if (rd_last_out)    n_last++;
            if (sweep_done_out) n_done++;
            step();
        end
        capture_in  = 1'b0;
        live_in     = 1'b0;
        rd_ready_in = 1'b0;
        #3;
        check("sweep_all_addr", exp_addr, FP);
        check("sweep_drained", sb.size(), 0);
        check("sweep_last_once", n_last, 1);
        check("sweep_done_once", n_done, 1);
        check("sweep_end_frozen", frozen_out, 1'b1);
        check("sweep_end_busy", busy_out, 1'b0);
        step();
    endtask

    initial begin
        int  hit;
        int  cnt;
        rst_in = 1'b1; capture_in = 1'b0; live_in = 1'b0; sweep_start_in = 1'b0;
        frame_start_in = 1'b0; pixel_valid_in = 1'b0; rd_ready_in = 1'b0;

        vt[0] = '{pix: 1'b1, rdy: 1'b0, live: 1'b0, exp_wea: 1'b1};
        vt[1] = '{pix: 1'b0, rdy: 1'b1, live: 1'b0, exp_wea: 1'b0};
        vt[2] = '{pix: 1'b1, rdy: 1'b1, live: 1'b1, exp_wea: 1'b1};
        vt[3] = '{pix: 1'b0, rdy: 1'b0, live: 1'b1, exp_wea: 1'b0};
        vt[4] = '{pix: 1'b1, rdy: 1'b1, live: 1'b0, exp_wea: 1'b1};
        vt[5] = '{pix: 1'b0, rdy: 1'b0, live: 1'b0, exp_wea: 1'b0};

        step();
        step();
        #3;
        check("rst_wea", wea_out, 1'b0);
        check("rst_frozen", frozen_out, 1'b0);
        check("rst_busy", busy_out, 1'b0);
        check("rst_done", capture_done_out, 1'b0);
        check("rst_rd_en", rd_en_out, 1'b0);
        check("rst_rd_addr", rd_addr_out, 0);
        check("rst_rd_valid", rd_valid_out, 1'b0);
        check("rst_rd_last", rd_last_out, 1'b0);
        check("rst_sweep_done", sweep_done_out, 1'b0);
        check("rst_retry", retry_count_out, 0);
        check("rst_timeout", timeout_out, 1'b0);
        rst_in = 1'b0;
        step();

        // LIVE mode: write enable follows the pixel strobe, nothing else moves.
        for (int i = 0; i < 6; i++) begin
            pixel_valid_in = vt[i].pix;
            rd_ready_in    = vt[i].rdy;
            live_in        = vt[i].live;
            #3;
            check("live_wea", wea_out, vt[i].exp_wea);
            check("live_frozen", frozen_out, 1'b0);
            check("live_busy", busy_out, 1'b0);
            check("live_rd_en", rd_en_out, 1'b0);
            check("live_rd_valid", rd_valid_out, 1'b0);
            check("live_timeout", timeout_out, 1'b0);
            step();
        end
        pixel_valid_in = 1'b0; rd_ready_in = 1'b0; live_in = 1'b0;

        // Full capture; frame start coincides with the final pixel.
        capture_pulse();
        arm_and_start();
        finish_capture(1'b1, 8'd0);

        full_sweep();

        // Capture beats sweep in FROZEN; live_in ignored while armed.
        capture_in = 1'b1; sweep_start_in = 1'b1; rd_ready_in = 1'b1;
        #3;
        step();
        capture_in = 1'b0; sweep_start_in = 1'b0;
        live_in = 1'b1;
        arm_and_start();
        live_in = 1'b0;

        // Short frame, then a complete one.
        feed_pixels(1000, 1'b0);
        pixel_valid_in = 1'b0;
        frame_start_in = 1'b1;
        #3;
        step();
        frame_start_in = 1'b0;
        #3;
        check("short_retry", retry_count_out, 8'd1);
        check("short_busy", busy_out, 1'b1);
        check("short_frozen", frozen_out, 1'b0);
        finish_capture(1'b0, 8'd1);

        // live_in alone returns to LIVE.
        live_in = 1'b1;
        #3;
        step();
        live_in = 1'b0;
        #3;
        check("back_live_frozen", frozen_out, 1'b0);
        check("back_live_busy", busy_out, 1'b0);
        step();

        // Reset in the middle of a sweep drops in-flight reads.
        capture_pulse();
        arm_and_start();
        finish_capture(1'b0, 8'd1);
        sweep_start_in = 1'b1;
        #3;
        step();
        sweep_start_in = 1'b0;
        hit = 0;
        for (int k = 0; k < 400; k++) begin
            rd_ready_in = 1'b1;
            #3;
            if (rd_en_out && rd_addr_out == 17'd300) begin
                rst_in = 1'b1;
                hit    = 1;
            end
            step();
            if (hit != 0) break;
        end
        rst_in = 1'b0;
        check("reached_addr_300", hit, 1);
        for (int k = 0; k < 8; k++) begin
            #3;
            check("post_rst_valid", rd_valid_out, 1'b0);
            check("post_rst_rd_en", rd_en_out, 1'b0);
            check("post_rst_frozen", frozen_out, 1'b0);
            check("post_rst_busy", busy_out, 1'b0);
            check("post_rst_retry", retry_count_out, 0);
            step();
        end
        rd_ready_in = 1'b0;

`ifdef CAPTURE_TIMEOUT_EN
        // No frame start: watchdog returns to LIVE after TO cycles armed.
        capture_pulse();
        cnt = 0;
        for (int k = 0; k < 3 * TO; k++) begin
            #3;
            if (timeout_out) break;
            if (busy_out) cnt++;
            step();
        end
        check("timeout_pulse", timeout_out, 1'b1);
        check("timeout_cycles", cnt, TO);
        check("timeout_busy", busy_out, 1'b0);
        check("timeout_frozen", frozen_out, 1'b0);
        step();
        #3;
        check("timeout_single", timeout_out, 1'b0);
        step();
`else
        // Without the watchdog, ARM waits indefinitely.
        capture_pulse();
        cnt = 0;
        for (int k = 0; k < 3 * TO; k++) begin
            #3;
            if (busy_out && !timeout_out) cnt++;
            step();
        end
        check("no_timeout_wait", cnt, 3 * TO);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
